// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions for the 7-segment scan controller and its decoder.
package seg_scan_ctrl_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam bcd_t       CODE_BLANK = 4'hF;
  localparam bcd_t       CODE_DP    = 4'hA;

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// BCD to active-low 7-segment decoder, {dp,g..a}; code A lights only the dp, B..F are dark.
module bcd_to_segment
  import seg_scan_ctrl_pkg::*;
(
  input  bcd_t       code,
  output logic [7:0] seg_n
);

  always_comb begin
    case (code)
      4'h0:    seg_n = 8'hC0;
      4'h1:    seg_n = 8'hF9;
      4'h2:    seg_n = 8'hA4;
      4'h3:    seg_n = 8'hB0;
      4'h4:    seg_n = 8'h99;
      4'h5:    seg_n = 8'h92;
      4'h6:    seg_n = 8'h82;
      4'h7:    seg_n = 8'hF8;
      4'h8:    seg_n = 8'h80;
      4'h9:    seg_n = 8'h90;
      CODE_DP: seg_n = 8'h7F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered frame
// load, per-slot dead-time and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     an_n,
  output logic [7:0]            seg_n,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                pend;
  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] active_bcd;
  logic [DIGITS-1:0]   active_dp;

  logic                slot_end;
  logic                scan_end;
  logic                accept;

  logic [DIGITS-1:0]   lz_mask_p0;
  bcd_t                code_p0;
  logic                dp_p0;
  logic                in_blank_p0;
  logic [7:0]          dec_seg_p0;
  logic [7:0]          seg_p0;
  logic [DIGITS-1:0]   an_p0;
  logic                vld_p0;

  // Digit k>=1 is dark when it and every digit above it is a zero with no dp.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] bcd,
                                                input logic [DIGITS-1:0]   dp,
                                                input logic                en);
    logic [DIGITS-1:0] mask;
    logic              run;
    mask = '0;
    run  = en;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run     = run && (bcd[4*k +: 4] == 4'h0) && !dp[k];
      mask[k] = run;
    end
    return mask;
  endfunction

  assign load_ready = !pend;
  assign accept     = load_valid && load_ready;
  assign slot_end   = (cnt == CNT_W'(SLOT_CYC - 1));
  assign scan_end   = slot_end && (idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      active_bcd <= {DIGITS{CODE_BLANK}};
      active_dp  <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= scan_end ? '0 : idx + 1'b1;
      end
      // pend blocks accept, so apply and accept never share a cycle.
      if (scan_end && pend) begin
        active_bcd <= shadow_bcd;
        active_dp  <= shadow_dp;
        pend       <= 1'b0;
      end else if (accept) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_bcd <= bcd_in;
      shadow_dp  <= dp_in;
    end
  end

  // Stage p0: digit select, blanking and decode from the current cnt/idx.
  always_comb begin
    lz_mask_p0  = lz_mask(active_bcd, active_dp, lz_blank);
    code_p0     = lz_mask_p0[idx] ? CODE_BLANK : active_bcd[{idx, 2'b00} +: 4];
    dp_p0       = active_dp[idx];
    in_blank_p0 = (cnt < CNT_W'(BLANK_CYC));
    seg_p0      = in_blank_p0 ? SEG_OFF : (dec_seg_p0 & {~dp_p0, 7'h7F});
    an_p0       = in_blank_p0 ? '1 : ~(DIGITS'(1) << idx);
    vld_p0      = (cnt == '0) && (idx == '0);
  end

  bcd_to_segment u_dec (
    .code  (code_p0),
    .seg_n (dec_seg_p0)
  );

  // Stage p1: registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n        <= '1;
      seg_n       <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      an_n        <= an_p0;
      seg_n       <= seg_p0;
      frame_start <= vld_p0;
    end
  end

endmodule
